// File: rtl/junction_pkg.sv
// rtl/junction_pkg.sv - shared states, signal aspects and width helper for the junction arbiter
package junction_pkg;

  localparam logic [5:0] ST_IDLE_OH     = 6'b000001;
  localparam logic [5:0] ST_SETTLE_OH   = 6'b000010;
  localparam logic [5:0] ST_GRANT_OH    = 6'b000100;
  localparam logic [5:0] ST_OCCUPIED_OH = 6'b001000;
  localparam logic [5:0] ST_RELEASE_OH  = 6'b010000;
  localparam logic [5:0] ST_FAULT_OH    = 6'b100000;

  typedef enum logic [5:0] {
    ST_IDLE     = ST_IDLE_OH,
    ST_SETTLE   = ST_SETTLE_OH,
    ST_GRANT    = ST_GRANT_OH,
    ST_OCCUPIED = ST_OCCUPIED_OH,
    ST_RELEASE  = ST_RELEASE_OH,
    ST_FAULT    = ST_FAULT_OH
  } state_e;

  localparam logic [1:0] SIG_STOP = 2'b00;
  localparam logic [1:0] SIG_GO   = 2'b01;

  function automatic int line_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/junction_arbiter_rr.sv
// rtl/junction_arbiter_rr.sv - combinational round-robin picker (first request at or above ptr, wrapping)
module rr_arbiter
  import junction_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = line_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] j;
  int            jj;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    jj    = 0;
    for (int i = 0; i < N; i++) begin
      jj = int'(ptr) + i;
      if (jj >= N) jj = jj - N;
      j = IW'(jj);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/junction_arbiter.sv
// rtl/junction_arbiter.sv - single-track junction scheduler: round-robin grant, switch settle,
// occupancy tracking, clearance hold and sticky fault.
module junction_arbiter
  import junction_pkg::*;
#(
  parameter int N_LINES    = 4,
  parameter int SW_SETTLE  = 8,
  parameter int CLEAR_HOLD = 4,
  parameter int TIMEOUT    = 1023,
  localparam int IW        = line_w(N_LINES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_LINES-1:0]   approach,
  input  logic                 entry,
  input  logic                 exit,
  output logic [IW-1:0]        sw_pos,
  output logic                 sw_move,
  output logic [2*N_LINES-1:0] sig,
  output logic [N_LINES-1:0]   grant,
  output logic                 busy,
  output logic                 alarm
);

  localparam int CMAX = (SW_SETTLE > CLEAR_HOLD) ? SW_SETTLE : CLEAR_HOLD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  state_e               st_q, st_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        to_q, to_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        sw_pos_q, sw_pos_d;
  logic [N_LINES-1:0]   own_q, own_d;
  logic [2*N_LINES-1:0] sig_q, sig_d;
  logic [N_LINES-1:0]   grant_q, grant_d;
  logic                 sw_move_q, sw_move_d;
  logic                 busy_q, busy_d;
  logic                 alarm_q, alarm_d;

  logic [N_LINES-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 timed_out;
  logic [TW-1:0]        to_inc;

  rr_arbiter #(.N(N_LINES), .IW(IW)) u_rr (
    .req (approach),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Fault fires on the edge where the counter would reach TIMEOUT.
  assign timed_out = (to_q >= TW'(TIMEOUT - 1));
  assign to_inc    = (to_q == TW'(TIMEOUT)) ? to_q : to_q + TW'(1);

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    rr_d     = rr_q;
    sw_pos_d = sw_pos_q;
    own_d    = own_q;
    case (st_q)
      ST_IDLE: begin
        if (entry) begin
          st_d = ST_FAULT;
        end else if (|approach) begin
          own_d = arb_gnt;
          if (arb_idx == sw_pos_q) begin
            st_d = ST_GRANT;
            to_d = '0;
          end else begin
            st_d     = ST_SETTLE;
            sw_pos_d = arb_idx;
            cnt_d    = CW'(SW_SETTLE);
          end
        end
      end
      ST_SETTLE: begin
        if (entry) begin
          st_d = ST_FAULT;
        end else if (cnt_q <= CW'(1)) begin
          st_d = ST_GRANT;
          to_d = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GRANT: begin
        to_d = to_inc;
        if (timed_out) begin
          st_d = ST_FAULT;
        end else if (entry) begin
          st_d = ST_OCCUPIED;
        end else if ((approach & own_q) == '0) begin
          st_d  = ST_RELEASE;
          cnt_d = CW'(CLEAR_HOLD);
        end
      end
      ST_OCCUPIED: begin
        to_d = to_inc;
        if (timed_out) begin
          st_d = ST_FAULT;
        end else if (exit) begin
          st_d  = ST_RELEASE;
          cnt_d = CW'(CLEAR_HOLD);
        end
      end
      ST_RELEASE: begin
        if (entry) begin
          st_d = ST_FAULT;
        end else if (cnt_q <= CW'(1)) begin
          st_d  = ST_IDLE;
          own_d = '0;
          rr_d  = (sw_pos_q == IW'(N_LINES - 1)) ? '0 : sw_pos_q + IW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_FAULT: st_d = ST_FAULT;
      default:  st_d = ST_FAULT;
    endcase

    sig_d = {N_LINES{SIG_STOP}};
    if (st_d == ST_GRANT) sig_d = (2*N_LINES)'(SIG_GO) << {sw_pos_d, 1'b0};
    grant_d   = (st_d == ST_GRANT || st_d == ST_OCCUPIED) ? own_d : '0;
    sw_move_d = (st_d == ST_SETTLE);
    busy_d    = (st_d != ST_IDLE);
    alarm_d   = alarm_q | (st_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      to_q      <= '0;
      rr_q      <= '0;
      sw_pos_q  <= '0;
      own_q     <= '0;
      sig_q     <= '0;
      grant_q   <= '0;
      sw_move_q <= 1'b0;
      busy_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      rr_q      <= rr_d;
      sw_pos_q  <= sw_pos_d;
      own_q     <= own_d;
      sig_q     <= sig_d;
      grant_q   <= grant_d;
      sw_move_q <= sw_move_d;
      busy_q    <= busy_d;
      alarm_q   <= alarm_d;
    end
  end

  assign sw_pos  = sw_pos_q;
  assign sw_move = sw_move_q;
  assign sig     = sig_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_junction_arbiter.sv
// tb/tb_junction_arbiter.sv - directed self-checking bench for junction_arbiter
module tb_junction_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] approach = '0;
  logic       entry = 1'b0;
  logic       exit = 1'b0;
  logic [1:0] sw_pos;
  logic       sw_move;
  logic [7:0] sig;
  logic [3:0] grant;
  logic       busy;
  logic       alarm;

  int checks = 0;
  int failures = 0;

  junction_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .approach (approach),
    .entry    (entry),
    .exit     (exit),
    .sw_pos   (sw_pos),
    .sw_move  (sw_move),
    .sig      (sig),
    .grant    (grant),
    .busy     (busy),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    approach = '0;
    entry    = 1'b0;
    exit     = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      approach = 4'($urandom);
      entry    = 1'($urandom);
      exit     = 1'($urandom);
      step();
    end
    checks++;
    if ({sig, sw_pos, sw_move, grant, busy, alarm} !== 17'h0) begin
      failures++;
      $display("FAIL reset_outputs: sig=%b sw_pos=%0d sw_move=%b grant=%b busy=%b alarm=%b, want all zero",
               sig, sw_pos, sw_move, grant, busy, alarm);
    end
    approach = '0; entry = 1'b0; exit = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0) begin
      failures++;
      $display("FAIL reset_release_idle: busy=%b grant=%b, want 0 and 0000", busy, grant);
    end
  endtask

  task automatic test_direct_grant();
    do_reset();
    approach = 4'b0001;
    step();
    checks++;
    if (sig !== 8'b0000_0001 || grant !== 4'b0001 || sw_move !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL direct_grant: sig=%b grant=%b sw_move=%b busy=%b, want 00000001 0001 0 1",
               sig, grant, sw_move, busy);
    end
    entry = 1'b1;
    step();
    entry = 1'b0; approach = '0;
    checks++;
    if (sig !== 8'b0 || grant !== 4'b0001) begin
      failures++;
      $display("FAIL occupied_stop: sig=%b grant=%b, want 00000000 0001", sig, grant);
    end
    exit = 1'b1;
    step();
    exit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b1 || grant !== 4'b0) begin
        failures++;
        $display("FAIL release_hold[%0d]: busy=%b grant=%b, want 1 0000", i, busy, grant);
      end
      if (i < 3) step();
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL release_end: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_settle();
    do_reset();
    approach = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 2) approach = 4'b0001;
      checks++;
      if (sw_move !== 1'b1 || sw_pos !== 2'd2 || sig !== 8'b0 || grant !== 4'b0) begin
        failures++;
        $display("FAIL settle[%0d]: sw_move=%b sw_pos=%0d sig=%b grant=%b, want 1 2 00000000 0000",
                 i, sw_move, sw_pos, sig, grant);
      end
    end
    approach = 4'b0100;
    step();
    checks++;
    if (sw_move !== 1'b0 || sig !== 8'b0001_0000 || grant !== 4'b0100) begin
      failures++;
      $display("FAIL settle_go: sw_move=%b sig=%b grant=%b, want 0 00010000 0100", sw_move, sig, grant);
    end
  endtask

  task automatic test_withdraw_and_same_cycle();
    do_reset();
    approach = 4'b0001;
    step();
    approach = 4'b0000;
    step();
    checks++;
    if (grant !== 4'b0 || busy !== 1'b1 || sig !== 8'b0) begin
      failures++;
      $display("FAIL withdraw: grant=%b busy=%b sig=%b, want 0000 1 00000000", grant, busy, sig);
    end
    do_reset();
    approach = 4'b0001;
    step();
    entry = 1'b1; exit = 1'b1;
    step();
    entry = 1'b0; exit = 1'b0;
    step();
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1 || sig !== 8'b0) begin
      failures++;
      $display("FAIL entry_exit_same: grant=%b busy=%b sig=%b, want 0001 1 00000000", grant, busy, sig);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    approach = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp = 4'b0001 << k;
      for (int n = 0; n < 30 && grant == 4'b0; n++) step();
      checks++;
      if (grant !== exp) begin
        failures++;
        $display("FAIL rr_grant[%0d]: grant=%b, want %b", k, grant, exp);
      end
      entry = 1'b1;
      step();
      entry = 1'b0; exit = 1'b1;
      step();
      exit = 1'b0;
    end
  endtask

  task automatic test_intrusion();
    do_reset();
    entry = 1'b1;
    step();
    entry = 1'b0;
    checks++;
    if (alarm !== 1'b1 || sig !== 8'b0 || grant !== 4'b0 || sw_move !== 1'b0) begin
      failures++;
      $display("FAIL intrusion: alarm=%b sig=%b grant=%b sw_move=%b, want 1 00000000 0000 0",
               alarm, sig, grant, sw_move);
    end
    approach = 4'b1111;
    repeat (12) step();
    checks++;
    if (alarm !== 1'b1 || grant !== 4'b0 || sig !== 8'b0) begin
      failures++;
      $display("FAIL fault_sticky: alarm=%b grant=%b sig=%b, want 1 0000 00000000", alarm, grant, sig);
    end
    do_reset();
    checks++;
    if (alarm !== 1'b0) begin
      failures++;
      $display("FAIL alarm_cleared: alarm=%b, want 0", alarm);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    approach = 4'b0001;
    step();
    n = 0;
    while (alarm !== 1'b1 && n < 1100) begin
      step();
      n++;
    end
    checks++;
    if (n != 1023) begin
      failures++;
      $display("FAIL timeout_cycles: alarm after %0d cycles, want 1023", n);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    approach = 4'b0010;
    for (int n = 0; n < 30 && grant == 4'b0; n++) step();
    entry = 1'b1;
    step();
    entry = 1'b0;
    checks++;
    if (grant !== 4'b0010 || sw_pos !== 2'd1) begin
      failures++;
      $display("FAIL pre_async: grant=%b sw_pos=%0d, want 0010 1", grant, sw_pos);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({sig, sw_pos, sw_move, grant, busy, alarm} !== 17'h0) begin
      failures++;
      $display("FAIL async_reset: sig=%b sw_pos=%0d sw_move=%b grant=%b busy=%b alarm=%b, want all zero",
               sig, sw_pos, sw_move, grant, busy, alarm);
    end
    approach = '0;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0) begin
      failures++;
      $display("FAIL async_reset_release: busy=%b grant=%b, want 0 0000", busy, grant);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_direct_grant();
    test_settle();
    test_withdraw_and_same_cycle();
    test_round_robin();
    test_intrusion();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
